goal_sprite_renderer: RTL and testbench
=======================================

// Module: goal_sprite_renderer
// PURPOSE
//   Downstream consumer of the goal sprite RAM: turns VGA scan coordinates into
//   sprite RAM read addresses, realigns the 1-cycle RAM read, maps the 5-bit
//   palette index to 24-bit RGB, and flashes the goal white after a score.
//   Sits between the VGA controller / game logic and the colour mux.
// PARAMETERS
//   SPRITE_W      70    sprite width in pixels (SPRITE_W*SPRITE_H <= 16384)
//   SPRITE_H      165   sprite height in pixels (11550 words in the RAM)
//   FLASH_FRAMES  8     frames per flash half-period
//   FLASH_TOGGLES 6     half-periods per flash burst (even = ends unlit)
// PORTS
//   Clk          in   1   system clock
//   Reset        in   1   synchronous, active-high reset
//   DrawX        in   10  current pixel column, 0..639
//   DrawY        in   10  current pixel row, 0..479
//   frame_start  in   1   1-cycle pulse at start of each frame
//   goal_x       in   10  sprite top-left column, sampled on frame_start
//   goal_y       in   10  sprite top-left row, sampled on frame_start
//   goal_scored  in   1   1-cycle pulse: start or restart a flash burst
//   rom_addr     out  14  read address to sprite RAM
//   rom_data     in   5   palette index, valid 1 clk after rom_addr
//   pixel_on     out  1   1 = opaque goal pixel at this output cycle
//   red,green,blue out 8 each  pixel colour; 0 when pixel_on=0
// BEHAVIOUR
//   - goal_x/goal_y latched into internal regs on frame_start only; no tearing.
//   - S0 (comb): in_box = DrawX>=gx && DrawX<gx+SPRITE_W && same for Y; compare
//     in 11 bits so gx+SPRITE_W > 1023 cannot wrap. rel = Draw-g.
//   - S1 (reg): rom_addr <= in_box ? rel_y*SPRITE_W+rel_x : 0; in_box_d1 <= in_box.
//   - S2: RAM returns rom_data; in_box_d2 <= in_box_d1; flash_d2 <= flash_lit.
//   - S3 (reg): pixel_on <= in_box_d2 && rom_data!=0; RGB <= pixel_on ?
//     (flash_d2 ? 24'hFFFFFF : PALETTE[rom_data]) : 0.
//   - Total latency DrawX/DrawY -> pixel_on/RGB = 3 clocks; throughput 1/clk.
//   - Index 0 is transparent. Index >= PALETTE_SIZE outputs magenta 24'hFF00FF.
//   - Flash FSM: IDLE -> LIT on goal_scored. LIT<->DARK toggle every FLASH_FRAMES
//     frame_start pulses; toggle counter increments per transition; after
//     FLASH_TOGGLES transitions -> IDLE. flash_lit = (state==LIT).
//   - goal_scored while LIT/DARK: restart at LIT, counters cleared.
//   - goal_scored and frame_start same cycle: restart wins; frame not counted.
//   - Reset: rom_addr=0, pixel_on=0, RGB=0, pipeline valids=0, FSM=IDLE,
//     counters=0, latched gx/gy=0. Reset mid-burst aborts flash immediately.
// STRUCTURE
//   goal_pkg: flash_state_t enum {IDLE,LIT,DARK}; PALETTE_SIZE; 24-bit
//     PALETTE[] constant table; TRANSPARENT_IDX=5'd0; FLASH_RGB, ERR_RGB.
//   Sub-module goal_flash_fsm (Clk, Reset, frame_start, goal_scored ->
//     flash_lit); everything else (address pipe, palette lookup) lives here.
// TESTING
//   - Reset, then gx=100,gy=200 via frame_start; DrawX=100,DrawY=200 ->
//     rom_addr=0 at +1 clk; DrawX=169,DrawY=364 -> rom_addr=11549.
//   - DrawX=99 or 170 (gy inside) -> rom_addr=0, pixel_on=0 three clocks later.
//   - RAM model index 3 at addr 71 (DrawX=101,DrawY=201) -> pixel_on=1,
//     RGB=PALETTE[3] exactly 3 clocks after the coordinate; index 0 -> pixel_on=0.
//   - gx=600: DrawX=639 in box, no wrap at 1023; gx=1000 -> never in_box.
//   - goal_scored, then 48 frame_start pulses -> RGB=FFFFFF for frames 0-7,
//     16-23, 32-39, palette otherwise; FSM IDLE after pulse 48.
//   - goal_scored at frame 10 of burst restarts LIT; Reset at frame 3 -> IDLE,
//     outputs 0 next clk, palette colours resume.

Source files
------------

// File: rtl/goal_pkg.sv
// ============================================================================
// Module   : goal_pkg
// Brief    : Shared types and colour constants for the goal sprite renderer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package goal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIT  = 2'd1,
    DARK = 2'd2
  } flash_state_t;

  localparam int          PALETTE_SIZE    = 16;
  localparam logic [4:0]  TRANSPARENT_IDX = 5'd0;
  localparam logic [23:0] FLASH_RGB       = 24'hFFFFFF;
  localparam logic [23:0] ERR_RGB         = 24'hFF00FF;

  localparam logic [23:0] PALETTE [PALETTE_SIZE] = '{
    24'h000000, 24'h202020, 24'hC0C0C0, 24'hE0E0E0,
    24'h808080, 24'h404040, 24'h00A000, 24'h006000,
    24'hFF0000, 24'h0000FF, 24'hFFFF00, 24'h00FFFF,
    24'h804000, 24'hA0A0FF, 24'h303060, 24'hF0F0F0
  };

  // Indices past the end of the table show up as magenta so bad art is visible.
  function automatic logic [23:0] palette_rgb(input logic [4:0] idx);
    if (idx < 5'(PALETTE_SIZE)) palette_rgb = PALETTE[idx[3:0]];
    else                        palette_rgb = ERR_RGB;
  endfunction

endpackage

`default_nettype wire

// File: rtl/goal_flash_fsm.sv
// ============================================================================
// Module   : goal_flash_fsm
// Brief    : Lit/dark blink sequencer for the goal after a score.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module goal_flash_fsm
  import goal_pkg::*;
#(
  parameter int FLASH_FRAMES  = 8,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic goal_scored,
  output logic flash_lit
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int TW = $clog2(FLASH_TOGGLES + 1);

  flash_state_t   r_state, w_state_nxt;
  logic [FW-1:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic [TW-1:0]  r_toggle_cnt, w_toggle_cnt_nxt;
  logic           w_period_end;
  logic           w_last_toggle;

  assign w_period_end  = (r_frame_cnt == FW'(FLASH_FRAMES - 1));
  assign w_last_toggle = (r_toggle_cnt == TW'(FLASH_TOGGLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_frame_cnt  <= '0;
      r_toggle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_toggle_cnt <= w_toggle_cnt_nxt;
    end
  end

  // A new score always wins, even over a coincident frame pulse.
  always_comb begin
    w_state_nxt      = r_state;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_toggle_cnt_nxt = r_toggle_cnt;
    if (goal_scored) begin
      w_state_nxt      = LIT;
      w_frame_cnt_nxt  = '0;
      w_toggle_cnt_nxt = '0;
    end else if (frame_start && r_state != IDLE) begin
      if (w_period_end) begin
        w_frame_cnt_nxt = '0;
        if (w_last_toggle) begin
          w_state_nxt      = IDLE;
          w_toggle_cnt_nxt = '0;
        end else begin
          w_state_nxt      = (r_state == LIT) ? DARK : LIT;
          w_toggle_cnt_nxt = r_toggle_cnt + TW'(1);
        end
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + FW'(1);
      end
    end
  end

  always_comb begin
    flash_lit = (r_state == LIT);
  end

endmodule

`default_nettype wire

// File: rtl/goal_sprite_renderer.sv
// ============================================================================
// Module   : goal_sprite_renderer
// Brief    : Scan position -> sprite RAM address -> palette RGB, 3-clock pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module goal_sprite_renderer
  import goal_pkg::*;
#(
  parameter int SPRITE_W      = 70,
  parameter int SPRITE_H      = 165,
  parameter int FLASH_FRAMES  = 8,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic [9:0]  goal_x,
  input  logic [9:0]  goal_y,
  input  logic        goal_scored,
  output logic [13:0] rom_addr,
  input  logic [4:0]  rom_data,
  output logic        pixel_on,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  logic [9:0]  r_gx, r_gy;
  logic [10:0] w_x_end, w_y_end;
  logic        w_in_box;
  logic [9:0]  w_rel_x, w_rel_y;
  logic [13:0] w_addr;
  logic [13:0] r_rom_addr;
  logic        r_in_box_d1, r_in_box_d2, r_flash_d2;
  logic        w_flash_lit;
  logic        w_opaque;
  logic [23:0] w_rgb;
  logic        r_pixel_on;
  logic [23:0] r_rgb;

  goal_flash_fsm #(
    .FLASH_FRAMES  (FLASH_FRAMES),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) u_flash_fsm (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .goal_scored (goal_scored),
    .flash_lit   (w_flash_lit)
  );

  // Box edges in 11 bits so a sprite hanging off the right/bottom never wraps.
  assign w_x_end  = {1'b0, r_gx} + 11'(SPRITE_W);
  assign w_y_end  = {1'b0, r_gy} + 11'(SPRITE_H);
  assign w_in_box = ({1'b0, DrawX} >= {1'b0, r_gx}) && ({1'b0, DrawX} < w_x_end) &&
                    ({1'b0, DrawY} >= {1'b0, r_gy}) && ({1'b0, DrawY} < w_y_end);
  assign w_rel_x  = DrawX - r_gx;
  assign w_rel_y  = DrawY - r_gy;
  assign w_addr   = 14'(w_rel_y) * 14'(SPRITE_W) + 14'(w_rel_x);

  assign w_opaque = r_in_box_d2 && (rom_data != TRANSPARENT_IDX);
  assign w_rgb    = !w_opaque  ? 24'h000000 :
                    r_flash_d2 ? FLASH_RGB  : palette_rgb(rom_data);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_gx        <= '0;
      r_gy        <= '0;
      r_rom_addr  <= '0;
      r_in_box_d1 <= 1'b0;
      r_in_box_d2 <= 1'b0;
      r_flash_d2  <= 1'b0;
      r_pixel_on  <= 1'b0;
      r_rgb       <= '0;
    end else begin
      if (frame_start) begin
        r_gx <= goal_x;
        r_gy <= goal_y;
      end
      r_rom_addr  <= w_in_box ? w_addr : 14'd0;
      r_in_box_d1 <= w_in_box;
      r_in_box_d2 <= r_in_box_d1;
      r_flash_d2  <= w_flash_lit;
      r_pixel_on  <= w_opaque;
      r_rgb       <= w_rgb;
    end
  end

  assign rom_addr = r_rom_addr;
  assign pixel_on = r_pixel_on;
  assign red      = r_rgb[23:16];
  assign green    = r_rgb[15:8];
  assign blue     = r_rgb[7:0];

endmodule

`default_nettype wire

// File: tb/tb_goal_sprite_renderer.sv
// ============================================================================
// Module   : tb_goal_sprite_renderer
// Brief    : Scoreboard bench for goal_sprite_renderer with a sync-read RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_goal_sprite_renderer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  goal_x = '0, goal_y = '0;
  logic        goal_scored = 1'b0;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic        pixel_on;
  logic [7:0]  red, green, blue;

  goal_sprite_renderer dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .goal_x(goal_x), .goal_y(goal_y),
    .goal_scored(goal_scored), .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_on(pixel_on), .red(red), .green(green), .blue(blue)
  );

  always #5 Clk = ~Clk;

  logic [4:0] ram [16384];
  always @(posedge Clk) rom_data <= ram[rom_addr];

  typedef struct {
    int          due;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q_addr[$];
  exp_t q_pix[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int m_gx = 0, m_gy = 0;
  int m_frames = 0;
  bit m_active = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pal(input logic [4:0] idx);
    case (idx)
      5'd0:  return 24'h000000;  5'd1:  return 24'h202020;
      5'd2:  return 24'hC0C0C0;  5'd3:  return 24'hE0E0E0;
      5'd4:  return 24'h808080;  5'd5:  return 24'h404040;
      5'd6:  return 24'h00A000;  5'd7:  return 24'h006000;
      5'd8:  return 24'hFF0000;  5'd9:  return 24'h0000FF;
      5'd10: return 24'hFFFF00;  5'd11: return 24'h00FFFF;
      5'd12: return 24'h804000;  5'd13: return 24'hA0A0FF;
      5'd14: return 24'h303060;  5'd15: return 24'hF0F0F0;
      default: return 24'hFF00FF;
    endcase
  endfunction

  function automatic bit model_lit();
    return m_active && ((m_frames / 8) % 2 == 0);
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
      e = q_addr.pop_front();
      chk(e.tag, 32'(rom_addr), e.val);
    end
    while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
      e = q_pix.pop_front();
      chk(e.tag, {7'd0, pixel_on, red, green, blue}, e.val);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic px(input int x, input int y, input string tag);
    bit         inb, pon;
    int         a;
    logic [4:0] idx;
    logic [23:0] rgb;
    DrawX = 10'(x);
    DrawY = 10'(y);
    inb = (x >= m_gx) && (x < m_gx + 70) && (y >= m_gy) && (y < m_gy + 165);
    a   = inb ? (y - m_gy) * 70 + (x - m_gx) : 0;
    idx = ram[a];
    pon = inb && (idx != 5'd0);
    rgb = !pon ? 24'h0 : (model_lit() ? 24'hFFFFFF : exp_pal(idx));
    q_addr.push_back('{cyc + 1, 32'(a), {tag, "/addr"}});
    q_pix.push_back('{cyc + 3, {7'd0, pon, rgb}, {tag, "/pix"}});
    tick();
  endtask

  task automatic frame(input int gx, input int gy, input bit with_score);
    goal_x = 10'(gx);
    goal_y = 10'(gy);
    frame_start = 1'b1;
    goal_scored = with_score;
    tick();
    frame_start = 1'b0;
    goal_scored = 1'b0;
    m_gx = gx;
    m_gy = gy;
    if (with_score) begin
      m_active = 1;
      m_frames = 0;
    end else if (m_active) begin
      m_frames++;
      if (m_frames == 48) m_active = 0;
    end
    settle();
  endtask

  task automatic score();
    goal_scored = 1'b1;
    tick();
    goal_scored = 1'b0;
    m_active = 1;
    m_frames = 0;
    settle();
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) ram[a] = 5'(a % 31);
    ram[71]  = 5'd3;
    ram[72]  = 5'd0;
    ram[720] = 5'd20;

    Reset = 1'b1;
    repeat (3) tick();
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix", {7'd0, pixel_on, red, green, blue}, 32'd0);
    Reset = 1'b0;
    tick();

    frame(100, 200, 0);
    px(100, 200, "origin");
    px(169, 364, "last");
    px(99, 250, "left_out");
    px(170, 250, "right_out");
    px(101, 201, "idx3");
    px(102, 201, "transp");
    px(120, 210, "magenta");
    px(150, 199, "above");
    px(150, 365, "below");
    for (int i = 0; i < 20; i++)
      px($urandom_range(90, 180), $urandom_range(190, 375), "rand");
    settle();

    frame(600, 200, 0);
    px(639, 250, "rt_edge");
    px(600, 200, "rt_org");
    px(599, 200, "rt_out");
    settle();
    frame(1000, 200, 0);
    for (int x = 0; x < 640; x += 71) px(x, 250, "far_out");
    px(639, 300, "far_639");
    settle();

    frame(100, 200, 0);
    score();
    for (int n = 0; n <= 48; n++) begin
      px(101, 201, "burst");
      px(130, 260, "burst2");
      settle();
      if (n < 48) frame(100, 200, 0);
    end

    score();
    for (int n = 0; n < 10; n++) frame(100, 200, 0);
    px(101, 201, "pre_restart");
    settle();
    frame(100, 200, 1);
    px(101, 201, "restart");
    settle();
    for (int n = 0; n < 7; n++) frame(100, 200, 0);
    px(101, 201, "restart_f7");
    settle();
    frame(100, 200, 0);
    px(101, 201, "restart_f8");
    settle();

    score();
    for (int n = 0; n < 3; n++) frame(100, 200, 0);
    px(101, 201, "pre_reset");
    settle();
    DrawX = 10'd101;
    DrawY = 10'd201;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_pix", {7'd0, pixel_on, red, green, blue}, 32'd0);
    m_gx = 0;
    m_gy = 0;
    m_active = 0;
    m_frames = 0;
    settle();
    frame(100, 200, 0);
    px(101, 201, "post_reset");
    px(120, 210, "post_reset_mag");
    settle();

    chk("drain_addr", 32'(q_addr.size()), 32'd0);
    chk("drain_pix", 32'(q_pix.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1);
  end

endmodule

`default_nettype wire
